// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation mode encoding.
package usr_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        HOLD = 2'd0,
        SHL  = 2'd1,
        SHR  = 2'd2,
        LOAD = 2'd3
    } mode_e;

endpackage

// File: rtl/universal_shift_reg_if.sv
// Control/data bundle between a driver and the universal shift register.
interface universal_shift_reg_if
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             En;
    mode_e            Mode;
    logic             Rotate;
    logic             SerIn;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qb;
    logic             SerOut;
    logic [CW-1:0]    Count;
    logic             Done;

    modport master (
        output En, Mode, Rotate, SerIn, D,
        input  Q, Qb, SerOut, Count, Done
    );

    modport slave (
        input  En, Mode, Rotate, SerIn, D,
        output Q, Qb, SerOut, Count, Done
    );

endinterface

// File: rtl/usr_bit_cell.sv
// One register bit: 4:1 next-state select (hold/left/right/load) and a flop
// with a synchronous reset value.
module usr_bit_cell
    import usr_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  en_i,
    input  mode_e mode_i,
    input  logic  shl_in_i,
    input  logic  shr_in_i,
    input  logic  load_in_i,
    output logic  q_o
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            unique case (mode_i)
                HOLD: q_d = q_q;
                SHL:  q_d = shl_in_i;
                SHR:  q_d = shr_in_i;
                LOAD: q_d = load_in_i;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= RESET_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift left/right (serial or rotate), parallel
// load, with a saturating shift counter and registered serial output.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                   Clock,
    input logic                   Reset,
    universal_shift_reg_if.slave  bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] shl_vec;
    logic [WIDTH-1:0] shr_vec;
    logic             shl_in;
    logic             shr_in;

    logic             serout_d;
    logic             serout_q;
    logic [CW-1:0]    count_d;
    logic [CW-1:0]    count_q;

    // Rotation feeds the bit leaving one end back into the other.
    assign shl_in  = bus.Rotate ? q[WIDTH-1] : bus.SerIn;
    assign shr_in  = bus.Rotate ? q[0] : bus.SerIn;
    assign shl_vec = {q[WIDTH-2:0], shl_in};
    assign shr_vec = {shr_in, q[WIDTH-1:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        usr_bit_cell #(
            .RESET_BIT (RESET_VAL[i])
        ) u_cell (
            .clk_i     (Clock),
            .rst_i     (Reset),
            .en_i      (bus.En),
            .mode_i    (bus.Mode),
            .shl_in_i  (shl_vec[i]),
            .shr_in_i  (shr_vec[i]),
            .load_in_i (bus.D[i]),
            .q_o       (q[i])
        );
    end

    always_comb begin
        serout_d = serout_q;
        count_d  = count_q;
        if (bus.En) begin
            unique case (bus.Mode)
                HOLD: ;
                SHL: begin
                    serout_d = q[WIDTH-1];
                    count_d  = (count_q == COUNT_MAX) ? count_q : count_q + CW'(1);
                end
                SHR: begin
                    serout_d = q[0];
                    count_d  = (count_q == COUNT_MAX) ? count_q : count_q + CW'(1);
                end
                LOAD: count_d = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            serout_q <= 1'b0;
            count_q  <= '0;
        end else begin
            serout_q <= serout_d;
            count_q  <= count_d;
        end
    end

    assign bus.Q      = q;
    assign bus.Qb     = ~q;
    assign bus.SerOut = serout_q;
    assign bus.Count  = count_q;
    assign bus.Done   = (count_q == COUNT_MAX);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8, RESET_VAL=0).
module tb_universal_shift_reg;
    import usr_pkg::*;

    logic Clock = 1'b0;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;

    universal_shift_reg_if #(.WIDTH(8)) bus ();

    universal_shift_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] q, input logic so,
                               input logic [3:0] cnt, input logic dn);
        check({tag, ".Q"}, {24'h0, bus.Q}, {24'h0, q});
        check({tag, ".Qb"}, {24'h0, bus.Qb}, {24'h0, ~q});
        check({tag, ".SerOut"}, {31'h0, bus.SerOut}, {31'h0, so});
        check({tag, ".Count"}, {28'h0, bus.Count}, {28'h0, cnt});
        check({tag, ".Done"}, {31'h0, bus.Done}, {31'h0, dn});
    endtask

    logic [7:0] rot_q  [8] = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
    logic       rot_so [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] shl_q  [5] = '{8'h78, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    logic       shl_so [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        // Reset overrides En/Mode for two edges.
        Reset = 1'b1;
        bus.En = 1'b1;
        bus.Mode = LOAD;
        bus.Rotate = 1'b0;
        bus.SerIn = 1'b0;
        bus.D = 8'hA5;
        #1;
        tick();
        tick();
        check_state("reset", 8'h00, 1'b0, 4'd0, 1'b0);

        // Load then serial shift-left with SerIn=1.
        Reset = 1'b0;
        tick();
        check_state("load_a5", 8'hA5, 1'b0, 4'd0, 1'b0);
        bus.Mode = SHL;
        bus.SerIn = 1'b1;
        tick();
        check_state("shl1", 8'h4B, 1'b1, 4'd1, 1'b0);
        tick();
        check_state("shl2", 8'h97, 1'b0, 4'd2, 1'b0);
        tick();
        check_state("shl3", 8'h2F, 1'b1, 4'd3, 1'b0);

        // Rotate right through a full cycle, then one more to test saturation.
        bus.Mode = LOAD;
        bus.D = 8'h81;
        tick();
        check_state("load_81", 8'h81, 1'b1, 4'd0, 1'b0);
        bus.Mode = SHR;
        bus.Rotate = 1'b1;
        bus.SerIn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_state($sformatf("rotr%0d", i + 1), rot_q[i], rot_so[i], 4'(i + 1),
                        (i == 7));
        end
        tick();
        check_state("rotr9_sat", 8'hC0, 1'b1, 4'd8, 1'b1);

        // Load after Done clears Count/Done on the same edge.
        bus.Mode = LOAD;
        bus.D = 8'hFF;
        tick();
        check_state("load_ff_after_done", 8'hFF, 1'b1, 4'd0, 1'b0);

        // En=0 freezes everything even with Mode=SHL.
        bus.D = 8'h3C;
        tick();
        check_state("load_3c", 8'h3C, 1'b1, 4'd0, 1'b0);
        bus.En = 1'b0;
        bus.Mode = SHL;
        bus.Rotate = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check_state("en0_hold", 8'h3C, 1'b1, 4'd0, 1'b0);
        bus.En = 1'b1;
        bus.Mode = HOLD;
        tick();
        check_state("mode_hold", 8'h3C, 1'b1, 4'd0, 1'b0);

        // Serial shift-left with SerIn=0 to Count=5, then reset mid-sequence.
        bus.Mode = SHL;
        bus.SerIn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_state($sformatf("shl0_%0d", i + 1), shl_q[i], shl_so[i], 4'(i + 1), 1'b0);
        end
        Reset = 1'b1;
        tick();
        check_state("mid_reset", 8'h00, 1'b0, 4'd0, 1'b0);
        Reset = 1'b0;
        bus.Mode = LOAD;
        bus.D = 8'h5A;
        tick();
        check_state("post_reset_load", 8'h5A, 1'b0, 4'd0, 1'b0);

        // Serial shift-right with SerIn=1.
        bus.Mode = SHR;
        bus.SerIn = 1'b1;
        tick();
        check_state("shr_ser", 8'hAD, 1'b0, 4'd1, 1'b0);
        tick();
        check_state("shr_ser2", 8'hD6, 1'b1, 4'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; SHALL be >= 2.
REQ-002 Parameter RESET_VAL, default '0, value loaded into Q on reset; SHALL be WIDTH bits.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 En  input  1  operation enable; 0 = hold all state.
REQ-006 Mode  input  2  operation select: HOLD=0, SHL=1, SHR=2, LOAD=3.
REQ-007 Rotate  input  1  1 = shifted-out bit re-enters at the opposite end instead of SerIn.
REQ-008 SerIn  input  1  serial data entering the vacated bit on a non-rotating shift.
REQ-009 D  input  WIDTH  parallel load data.
REQ-010 Q  output  WIDTH  register contents.
REQ-011 Qb  output  WIDTH  bitwise complement of Q.
REQ-012 SerOut  output  1  registered copy of the bit shifted out on the last shift.
REQ-013 Count  output  $clog2(WIDTH+1)  shifts since last load or reset, saturating.
REQ-014 Done  output  1  high when Count == WIDTH.

Function
REQ-015 Q, SerOut and Count SHALL update only on the rising Clock edge; latency from inputs to Q is exactly one edge.
REQ-016 Qb SHALL equal ~Q combinationally at all times.
REQ-017 En=0 (and Reset=0): Q, SerOut, Count SHALL hold regardless of Mode.
REQ-018 HOLD: Q, SerOut, Count SHALL hold.
REQ-019 LOAD: Q <= D; Count <= 0; SerOut holds.
REQ-020 SHL: Q <= {Q[WIDTH-2:0], in}; in = Rotate ? Q[WIDTH-1] : SerIn; SerOut <= Q[WIDTH-1].
REQ-021 SHR: Q <= {in, Q[WIDTH-1:1]}; in = Rotate ? Q[0] : SerIn; SerOut <= Q[0].
REQ-022 Each SHL/SHR edge SHALL increment Count by 1, saturating at WIDTH; further shifts leave Count == WIDTH.
REQ-023 Done SHALL be decoded combinationally from Count; no extra cycle of delay.
REQ-024 A LOAD after Done SHALL clear Count and Done on the same edge that loads Q.

Reset
REQ-025 Reset=1 at an edge SHALL force Q=RESET_VAL, SerOut=0, Count=0 (so Done=0, Qb=~RESET_VAL), overriding En and Mode.
REQ-026 Reset asserted mid shift sequence SHALL take effect on the next edge; partial shift state is discarded.
REQ-027 First edge after Reset deasserts SHALL perform the operation selected by En/Mode normally.

Structure
REQ-028 Package usr_pkg SHALL hold the Mode enum type (HOLD, SHL, SHR, LOAD) and its 2-bit width constant.
REQ-029 A sub-module usr_bit_cell (one-bit 4:1 next-state mux plus flop with synchronous reset value) SHALL be instantiated WIDTH times via generate.
REQ-030 Count/SerOut/Done logic SHALL reside in the top module.

Verification (WIDTH=8, RESET_VAL=8'h00)
REQ-031 Reset=1, En=1, Mode=LOAD, D=8'hA5 for 2 edges -> Q=8'h00, Qb=8'hFF, Count=0, Done=0.
REQ-032 LOAD 8'hA5, then SHL SerIn=1 Rotate=0 x3 -> Q=8'h4B, 8'h97, 8'h2F; SerOut=1,0,1; Count=3.
REQ-033 LOAD 8'h81, SHR Rotate=1 x8 -> Q after 1st edge 8'hC0, after 8th 8'h81; Done=1 at 8th edge; 9th shift keeps Count=8.
REQ-034 Q=8'h3C, En=0, Mode=SHL for 4 edges -> Q=8'h3C, Count and SerOut unchanged.
REQ-035 Reset=1 at Count=5 mid-SHL -> next edge Q=8'h00, Count=0, SerOut=0; Reset=0 with LOAD 8'h5A -> Q=8'h5A one edge later.
REQ-036 After Done=1, LOAD 8'hFF -> same edge Q=8'hFF, Count=0, Done=0.
